// File: rtl/uart_byte_rx_if.sv
// Byte-stream handshake and error pulses between the UART receiver and its consumer.
interface uart_byte_rx_if;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       framing_error;
  logic       overrun;

  modport master (
    output data_out,
    output valid_out,
    output framing_error,
    output overrun,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    input  framing_error,
    input  overrun,
    output ready_in
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a one-deep
// ready/valid holding register with framing-error and overrun pulses.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           serial_rx,
  uart_byte_rx_if.master bus
);

  localparam int          HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [11:0] HALF_LOAD = 12'(HALF_BIT - 1);
  localparam logic [11:0] BIT_LOAD  = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic        rx_meta;
  logic        rx_s;
  state_t      state;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        deliver;

  // Two-flop synchronizer; idle-high line resets to 1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM plus holding register; a good stop sample raises deliver,
  // which loads the holding register one edge later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= 12'd0;
      bit_idx           <= 3'd0;
      shift             <= 8'd0;
      deliver           <= 1'b0;
      bus.data_out      <= 8'd0;
      bus.valid_out     <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.framing_error <= 1'b0;
      bus.overrun       <= 1'b0;
      deliver           <= 1'b0;

      if (deliver) begin
        if (!bus.valid_out || bus.ready_in) begin
          bus.data_out  <= shift;
          bus.valid_out <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.valid_out && bus.ready_in) begin
        bus.valid_out <= 1'b0;
      end else begin
        bus.valid_out <= bus.valid_out;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (cnt == 12'd0) begin
            if (!rx_s) begin
              cnt     <= BIT_LOAD;
              bit_idx <= 3'd0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        DATA: begin
          if (cnt == 12'd0) begin
            shift[bit_idx] <= rx_s;
            cnt            <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        STOP: begin
          if (cnt == 12'd0) begin
            if (rx_s) begin
              deliver <= 1'b1;
              state   <= IDLE;
            end else begin
              bus.framing_error <= 1'b1;
              state             <= BRK;
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        // A held-low line stays here so it yields a single framing error
        BRK: begin
          if (rx_s) begin
            state <= IDLE;
          end else begin
            state <= BRK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed scenarios plus randomized frames checked against a frame-timing model.
module tb_uart_byte_rx;
  localparam int C         = 16;
  localparam int HALF      = C / 2;
  localparam int STOP_OFS  = 3 + HALF + 9 * C;  // line fall -> stop sample (2 sync flops + detect edge)
  localparam int RISE_OFS  = STOP_OFS + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic serial_rx = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLKS_PER_BIT(C)) dut (
    .clock     (clock),
    .reset     (reset),
    .serial_rx (serial_rx),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: records valid rises, transfers and error pulses
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  logic [7:0] got_q[$];
  int         fe_cnt = 0, ov_cnt = 0, fe_cyc = 0, ov_cyc = 0, run = 0, last_len = 0;
  logic       valid_d = 1'b0;

  always @(negedge clock) begin
    if (bus.valid_out && !valid_d) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(bus.data_out);
    end
    if (bus.valid_out && bus.ready_in) got_q.push_back(bus.data_out);
    if (bus.valid_out) run <= run + 1;
    else if (run != 0) begin
      last_len <= run;
      run      <= 0;
    end
    if (bus.framing_error) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (bus.overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    valid_d <= bus.valid_out;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, output int start);
    start = cyc;
    serial_rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      tick(C);
    end
    serial_rx = stop_v;
    tick(C);
  endtask

  int s, s2, b0, f0, o0, exp_fe;
  int ex_cyc[$];
  logic [7:0] ex_dat[$];
  logic [7:0] rb;

  initial begin
    bus.ready_in = 1'b0;
    tick(3);
    check_val("reset_outs", 32'({bus.data_out, bus.valid_out, bus.framing_error, bus.overrun}), 32'd0);
    reset = 1'b1;
    tick(5);

    // 1: single byte, consumer always ready
    bus.ready_in = 1'b1;
    b0 = rise_cyc.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h55, 1'b1, s);
    tick(20);
    check_val("s1_count", 32'(rise_cyc.size() - b0), 32'd1);
    check_val("s1_time", 32'(rise_cyc[b0] - s), 32'(RISE_OFS));
    check_val("s1_data", 32'(rise_dat[b0]), 32'h55);
    check_val("s1_len", 32'(last_len), 32'd1);
    check_val("s1_errs", 32'(fe_cnt - f0 + ov_cnt - o0), 32'd0);

    // 2: overrun while holding register full
    bus.ready_in = 1'b0;
    f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA3, 1'b1, s);
    send_frame(8'h3C, 1'b1, s2);
    tick(20);
    check_val("s2_data", 32'(bus.data_out), 32'hA3);
    check_val("s2_valid", 32'(bus.valid_out), 32'd1);
    check_val("s2_ov_cnt", 32'(ov_cnt - o0), 32'd1);
    check_val("s2_ov_time", 32'((ov_cyc - s2 >= STOP_OFS) && (ov_cyc - s2 <= RISE_OFS)), 32'd1);
    bus.ready_in = 1'b1;
    tick(1);
    bus.ready_in = 1'b0;
    check_val("s2_drain", 32'(bus.valid_out), 32'd0);
    check_val("s2_taken", 32'(got_q[got_q.size() - 1]), 32'hA3);
    check_val("s2_fe", 32'(fe_cnt - f0), 32'd0);

    // 3: short low glitch is ignored
    bus.ready_in = 1'b1;
    b0 = rise_cyc.size(); f0 = fe_cnt;
    serial_rx = 1'b0;
    tick(5);
    serial_rx = 1'b1;
    tick(30);
    check_val("s3_no_byte", 32'(rise_cyc.size() - b0), 32'd0);
    check_val("s3_no_fe", 32'(fe_cnt - f0), 32'd0);
    send_frame(8'hC4, 1'b1, s);
    tick(20);
    check_val("s3_count", 32'(rise_cyc.size() - b0), 32'd1);
    check_val("s3_data", 32'(rise_dat[b0]), 32'hC4);

    // 4: low stop bit followed by a break
    bus.ready_in = 1'b0;
    b0 = rise_cyc.size(); f0 = fe_cnt;
    send_frame(8'h6E, 1'b0, s);
    tick(40);
    check_val("s4_fe_cnt", 32'(fe_cnt - f0), 32'd1);
    check_val("s4_fe_time", 32'(fe_cyc - s), 32'(STOP_OFS));
    check_val("s4_no_byte", 32'(rise_cyc.size() - b0), 32'd0);
    serial_rx = 1'b1;
    tick(5);
    send_frame(8'h81, 1'b1, s);
    tick(20);
    check_val("s4_fe_once", 32'(fe_cnt - f0), 32'd1);
    check_val("s4_valid", 32'(bus.valid_out), 32'd1);
    check_val("s4_data", 32'(bus.data_out), 32'h81);

    // 5: reset in the middle of a frame
    serial_rx = 1'b0;
    tick(C);
    rb = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      serial_rx = rb[i];
      tick(C);
    end
    reset = 1'b0;
    serial_rx = 1'b1;
    #1;
    check_val("s5_in_reset", 32'({bus.data_out, bus.valid_out, bus.framing_error, bus.overrun}), 32'd0);
    tick(3);
    reset = 1'b1;
    b0 = rise_cyc.size();
    tick(200);
    check_val("s5_no_partial", 32'(bus.valid_out), 32'd0);
    check_val("s5_no_rise", 32'(rise_cyc.size() - b0), 32'd0);
    send_frame(8'hF0, 1'b1, s);
    tick(20);
    check_val("s5_valid", 32'(bus.valid_out), 32'd1);
    check_val("s5_data", 32'(bus.data_out), 32'hF0);

    // 6: back-to-back frames with no idle gap
    bus.ready_in = 1'b1;
    tick(2);
    b0 = rise_cyc.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h00, 1'b1, s);
    send_frame(8'hFF, 1'b1, s2);
    tick(20);
    check_val("s6_count", 32'(rise_cyc.size() - b0), 32'd2);
    check_val("s6_data0", 32'(rise_dat[b0]), 32'h00);
    check_val("s6_data1", 32'(rise_dat[b0 + 1]), 32'hFF);
    check_val("s6_spacing", 32'(rise_cyc[b0 + 1] - rise_cyc[b0]), 32'(10 * C));
    check_val("s6_errs", 32'(fe_cnt - f0 + ov_cnt - o0), 32'd0);

    // Random mix of good frames, glitches and bad-stop frames
    b0 = rise_cyc.size(); f0 = fe_cnt; o0 = ov_cnt; exp_fe = 0;
    for (int it = 0; it < 20; it++) begin
      int kind;
      kind = $urandom_range(0, 5);
      rb = 8'($urandom_range(0, 255));
      if (kind <= 3) begin
        send_frame(rb, 1'b1, s);
        ex_cyc.push_back(s + RISE_OFS);
        ex_dat.push_back(rb);
        tick($urandom_range(0, 12));
      end else if (kind == 4) begin
        serial_rx = 1'b0;
        tick($urandom_range(1, HALF - 2));
        serial_rx = 1'b1;
        tick(HALF + $urandom_range(1, 10));
      end else begin
        send_frame(rb, 1'b0, s);
        exp_fe++;
        tick($urandom_range(0, 30));
        serial_rx = 1'b1;
        tick($urandom_range(1, 10));
      end
    end
    serial_rx = 1'b1;
    tick(20);
    check_val("rnd_count", 32'(rise_cyc.size() - b0), 32'(ex_cyc.size()));
    for (int i = 0; i < ex_cyc.size(); i++) begin
      check_val($sformatf("rnd_time%0d", i), 32'(rise_cyc[b0 + i]), 32'(ex_cyc[i]));
      check_val($sformatf("rnd_data%0d", i), 32'(rise_dat[b0 + i]), 32'(ex_dat[i]));
    end
    check_val("rnd_fe", 32'(fe_cnt - f0), 32'(exp_fe));
    check_val("rnd_ov", 32'(ov_cnt - o0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- 8N1 UART receiver that sits directly upstream of the UART Wishbone command master on the iCEBreaker.
- Turns the serial_rx pin into a stream of bytes, delivered through a one-deep ready/valid holding register.
- Flags framing errors and overruns so the command layer can resync.
- Runs in the single system clock domain.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit time (12 MHz / 115200). Legal range 8..4095.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), offset from start detection to the start-bit sample point. Derived; not overridden.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- serial_rx  input  1  raw UART line, idle high, asynchronous to clock
- data_out  output  8  received byte, LSB = first data bit on the wire
- valid_out  output  1  data_out holds an unconsumed byte
- ready_in  input  1  consumer accepts the byte on a cycle where valid_out=1 and ready_in=1
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low
- overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register was full

Behaviour:

Reset (reset=0):
- All state clears immediately, without waiting for a clock edge.
- data_out=0, valid_out=0, framing_error=0, overrun=0.
- Synchronizer flops reset to 1. FSM goes to IDLE and the bit counter clears.
- Asserting reset mid-frame abandons the frame; no partial byte is ever presented.

Synchronizer:
- Two flops on serial_rx. The FSM uses only rx_s, the second flop's output.

FSM states and transitions:
- IDLE: when rx_s=0, load cnt=HALF_BIT-1 and go to START.
- START: decrement cnt. At cnt=0, sample rx_s.
  - rx_s=0: load cnt=CLKS_PER_BIT-1, clear bit index, go to DATA.
  - rx_s=1: glitch; go to IDLE with no output.
- DATA: decrement cnt. At cnt=0, shift rx_s into the shift register at bit index (LSB first) and reload cnt=CLKS_PER_BIT-1.
  - After the 8th bit, go to STOP.
- STOP: at cnt=0, sample rx_s.
  - rx_s=1: deliver the byte (see Holding register) and go to IDLE.
  - rx_s=0: pulse framing_error for one cycle, discard the byte, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line (break condition) therefore produces exactly one framing_error.

Sample timing:
- Take the IDLE edge that sees rx_s=0 as cycle 0.
- Start bit sampled at cycle HALF_BIT.
- Data bit i (i = 0..7) sampled at cycle HALF_BIT + (i+1)*CLKS_PER_BIT.
- Stop bit sampled at cycle HALF_BIT + 9*CLKS_PER_BIT.
- valid_out rises on the next edge after the stop sample.
- Return to IDLE happens at the stop sample, so the next start bit is detected with no dead time; back-to-back frames are supported.

Holding register:
- Transfer occurs when valid_out=1 and ready_in=1. valid_out clears on the next edge unless a new byte loads in the same cycle.
- Delivery with valid_out=0: load data_out and set valid_out=1.
- Delivery with valid_out=1 and ready_in=1 in the same cycle: the old byte transfers, the new byte loads, and valid_out stays 1.
- Delivery with valid_out=1 and ready_in=0: the new byte is dropped, data_out is unchanged, and overrun pulses for one cycle.
- data_out is stable whenever valid_out=1 and no transfer occurs.
- ready_in has no effect while valid_out=0.

Counter and outputs:
- cnt is 12 bits wide; it never wraps because it is reloaded at every sample point.
- framing_error and overrun are registered pulses, 0 except on their event cycle. Both may be 1 in the same cycle only if both events coincide (they cannot; each is tied to a different stop-bit outcome).

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Send 0x55 with ready_in=1 held → valid_out high for exactly 1 cycle, data_out=0x55, 153 cycles after the first IDLE edge seeing rx_s=0 (8 + 9*16 + 1); no error pulses.
2. Send 0xA3 with ready_in=0, then 0x3C → data_out stays 0xA3 and overrun pulses once at the 0x3C stop sample. Then assert ready_in=1 for 1 cycle → valid_out=0 on the next edge.
3. Drive serial_rx low for 5 cycles, then high → no valid_out and no framing_error; FSM back in IDLE. A following 0xC4 is received correctly.
4. Send a frame with a low stop bit and hold the line low 40 more cycles, then release and send 0x81 → exactly one framing_error pulse, no valid_out for the bad frame, then data_out=0x81 with valid_out=1.
5. Assert reset low after data bit 3 of 0x5A, release after 3 cycles → all outputs 0 during reset, no byte from the aborted frame. The next frame 0xF0 is received correctly.
6. Send 0x00 immediately followed by 0xFF (no idle gap), ready_in=1 held → two valid_out pulses carrying 0x00 then 0xFF, 160 cycles apart, no errors.
